// File: rtl/rob_unit.sv
// Reorder buffer: hands out tags in program order, answers operand queries with a writeback bypass,
// broadcasts writebacks one cycle later, commits in order and flushes when a mispredicted branch commits.
module rob_unit #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_decode_valid,
  input  logic [REG_W-1:0]  in_decode_rd,
  input  logic [DATA_W-1:0] in_decode_pc,
  output logic [TAG_W-1:0]  out_alloc_tag,
  output logic              out_full,
  input  logic [TAG_W-1:0]  in_query_tag_rs1,
  input  logic [TAG_W-1:0]  in_query_tag_rs2,
  output logic              out_ready_rs1,
  output logic              out_ready_rs2,
  output logic [DATA_W-1:0] out_value_rs1,
  output logic [DATA_W-1:0] out_value_rs2,
  input  logic              in_alu_valid,
  input  logic [TAG_W-1:0]  in_alu_tag,
  input  logic [DATA_W-1:0] in_alu_value,
  input  logic              in_alu_mispredict,
  input  logic [DATA_W-1:0] in_alu_target,
  output logic [TAG_W-1:0]  out_update_tag,
  output logic [DATA_W-1:0] out_update_value,
  output logic              out_commit_valid,
  output logic [TAG_W-1:0]  out_commit_tag,
  output logic [REG_W-1:0]  out_commit_rd,
  output logic [DATA_W-1:0] out_commit_value,
  output logic              out_flush,
  output logic [DATA_W-1:0] out_flush_pc
);
  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE - 1);

  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d, misp_q, misp_d;
  logic [REG_W-1:0]    rd_q     [ROB_SIZE];
  logic [REG_W-1:0]    rd_d     [ROB_SIZE];
  logic [DATA_W-1:0]   pc_q     [ROB_SIZE];
  logic [DATA_W-1:0]   pc_d     [ROB_SIZE];
  logic [DATA_W-1:0]   value_q  [ROB_SIZE];
  logic [DATA_W-1:0]   value_d  [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];
  logic [DATA_W-1:0]   target_d [ROB_SIZE];
  logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d, count_q, count_d;

  logic [TAG_W-1:0]    update_tag_q, update_tag_d, commit_tag_q, commit_tag_d;
  logic [DATA_W-1:0]   update_value_q, update_value_d, commit_value_q, commit_value_d;
  logic [DATA_W-1:0]   flush_pc_q, flush_pc_d;
  logic [REG_W-1:0]    commit_rd_q, commit_rd_d;
  logic                commit_valid_q, commit_valid_d, flush_q, flush_d;

  logic do_alloc, do_wb, do_commit, do_flush;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
  endfunction

  assign out_full      = (count_q == LAST_TAG);
  assign out_alloc_tag = out_full ? '0 : tail_q;
  assign do_alloc      = in_decode_valid && !out_full;
  assign do_wb         = in_alu_valid && (in_alu_tag != '0) && busy_q[in_alu_tag];
  // Commit looks only at registered readiness; a same-cycle writeback waits one cycle.
  assign do_commit     = (count_q != '0) && ready_q[head_q];
  assign do_flush      = do_commit && misp_q[head_q];

  logic [TAG_W-1:0]  q_tag   [2];
  logic [1:0]        q_ready;
  logic [DATA_W-1:0] q_value [2];

  assign q_tag[0] = in_query_tag_rs1;
  assign q_tag[1] = in_query_tag_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_query
      logic hit_wb;
      assign hit_wb       = in_alu_valid && (in_alu_tag == q_tag[gi]);
      assign q_ready[gi]  = (q_tag[gi] != '0) && busy_q[q_tag[gi]] && (ready_q[q_tag[gi]] || hit_wb);
      assign q_value[gi]  = hit_wb ? in_alu_value : value_q[q_tag[gi]];
    end
  endgenerate

  assign out_ready_rs1 = q_ready[0];
  assign out_ready_rs2 = q_ready[1];
  assign out_value_rs1 = q_value[0];
  assign out_value_rs2 = q_value[1];

  always_comb begin
    busy_d   = busy_q;
    ready_d  = ready_q;
    misp_d   = misp_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    value_d  = value_q;
    target_d = target_q;
    head_d   = head_q;
    tail_d   = tail_q;
    if (do_wb) begin
      ready_d[in_alu_tag]  = 1'b1;
      value_d[in_alu_tag]  = in_alu_value;
      misp_d[in_alu_tag]   = in_alu_mispredict;
      target_d[in_alu_tag] = in_alu_target;
    end
    if (do_alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = in_decode_rd;
      pc_d[tail_q]    = in_decode_pc;
      tail_d          = next_tag(tail_q);
    end
    if (do_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = next_tag(head_q);
    end
    count_d = count_q + TAG_W'(do_alloc) - TAG_W'(do_commit);
    if (do_flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = FIRST_TAG;
      tail_d  = FIRST_TAG;
      count_d = '0;
    end
  end

  always_comb begin
    update_tag_d   = (do_wb && !do_flush) ? in_alu_tag : '0;
    update_value_d = (do_wb && !do_flush) ? in_alu_value : '0;
    commit_valid_d = do_commit;
    commit_tag_d   = do_commit ? head_q : '0;
    commit_rd_d    = do_commit ? rd_q[head_q] : '0;
    commit_value_d = do_commit ? value_q[head_q] : '0;
    flush_d        = do_flush;
    flush_pc_d     = do_flush ? target_q[head_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= '0;
      ready_q        <= '0;
      misp_q         <= '0;
      head_q         <= FIRST_TAG;
      tail_q         <= FIRST_TAG;
      count_q        <= '0;
      update_tag_q   <= '0;
      update_value_q <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy) begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      misp_q         <= misp_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      update_tag_q   <= update_tag_d;
      update_value_q <= update_value_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Entry payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      value_q  <= value_d;
      target_q <= target_d;
    end
  end

  assign out_update_tag   = update_tag_q;
  assign out_update_value = update_value_q;
  assign out_commit_valid = commit_valid_q;
  assign out_commit_tag   = commit_tag_q;
  assign out_commit_rd    = commit_rd_q;
  assign out_commit_value = commit_value_q;
  assign out_flush        = flush_q;
  assign out_flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_rob_unit.sv
// Self-checking bench for rob_unit: directed scenarios plus a randomized run against an in-order queue model.
module tb_rob_unit;
  logic        clk, rst, rdy;
  logic        decode_valid;
  logic [4:0]  decode_rd;
  logic [31:0] decode_pc;
  logic [3:0]  alloc_tag;
  logic        full;
  logic [3:0]  qtag1, qtag2;
  logic        qready1, qready2;
  logic [31:0] qvalue1, qvalue2;
  logic        alu_valid;
  logic [3:0]  alu_tag;
  logic [31:0] alu_value;
  logic        alu_misp;
  logic [31:0] alu_target;
  logic [3:0]  upd_tag;
  logic [31:0] upd_value;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        flush;
  logic [31:0] flush_pc;

  rob_unit #(.ROB_SIZE(16), .TAG_W(4), .DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_decode_valid(decode_valid), .in_decode_rd(decode_rd), .in_decode_pc(decode_pc),
    .out_alloc_tag(alloc_tag), .out_full(full),
    .in_query_tag_rs1(qtag1), .in_query_tag_rs2(qtag2),
    .out_ready_rs1(qready1), .out_ready_rs2(qready2),
    .out_value_rs1(qvalue1), .out_value_rs2(qvalue2),
    .in_alu_valid(alu_valid), .in_alu_tag(alu_tag), .in_alu_value(alu_value),
    .in_alu_mispredict(alu_misp), .in_alu_target(alu_target),
    .out_update_tag(upd_tag), .out_update_value(upd_value),
    .out_commit_valid(commit_valid), .out_commit_tag(commit_tag),
    .out_commit_rd(commit_rd), .out_commit_value(commit_value),
    .out_flush(flush), .out_flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: in-flight tags kept in program order in a queue.
  int          mq[$];
  int          m_next = 1;
  bit          m_ready [16];
  bit          m_misp  [16];
  logic [31:0] m_val   [16];
  logic [31:0] m_tgt   [16];
  logic [4:0]  m_rd    [16];
  logic [3:0]  e_upd_tag = '0, e_ctag = '0;
  logic [31:0] e_upd_val = '0, e_cval = '0, e_fpc = '0;
  logic [4:0]  e_crd = '0;
  bit          e_cv = 0, e_flush = 0;

  function automatic bit m_busy(int t);
    foreach (mq[i]) if (mq[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_qready(int t);
    return (t != 0) && m_busy(t) && (m_ready[t] || (alu_valid && int'(alu_tag) == t));
  endfunction

  function automatic logic [31:0] m_qvalue(int t);
    return (alu_valid && int'(alu_tag) == t) ? alu_value : m_val[t];
  endfunction

  task automatic model_step();
    bit is_full, wb, cm, fl;
    int h, t;
    if (rst) begin
      mq.delete(); m_next = 1;
      e_upd_tag = '0; e_cv = 0; e_flush = 0;
      return;
    end
    if (!rdy) return;
    is_full = (mq.size() == 15);
    wb = alu_valid && alu_tag != 0 && m_busy(int'(alu_tag));
    cm = (mq.size() > 0) && m_ready[mq[0]];
    fl = cm && m_misp[mq[0]];
    e_cv = cm;
    e_flush = fl;
    if (cm) begin
      h = mq[0];
      e_ctag = 4'(h); e_crd = m_rd[h]; e_cval = m_val[h];
      if (fl) e_fpc = m_tgt[h];
    end
    e_upd_tag = (wb && !fl) ? alu_tag : 4'd0;
    e_upd_val = alu_value;
    if (wb) begin
      t = int'(alu_tag);
      m_ready[t] = 1'b1; m_val[t] = alu_value; m_misp[t] = alu_misp; m_tgt[t] = alu_target;
    end
    if (cm) void'(mq.pop_front());
    if (decode_valid && !is_full) begin
      m_ready[m_next] = 1'b0;
      m_rd[m_next] = decode_rd;
      mq.push_back(m_next);
      m_next = m_next % 15 + 1;
    end
    if (fl) begin
      mq.delete(); m_next = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    decode_valid = 0; decode_rd = '0; decode_pc = '0;
    alu_valid = 0; alu_tag = '0; alu_value = '0; alu_misp = 0; alu_target = '0;
    qtag1 = '0; qtag2 = '0;
  endtask

  task automatic do_reset();
    idle(); rdy = 1; rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    decode_valid = 1; decode_rd = rd; decode_pc = $urandom;
    tick();
    decode_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    qtag1 = 4'd1; #1;
    n_checks += 6;
    if (upd_tag !== 4'd0) begin n_errors++; $display("FAIL reset_update_tag got %0d want 0", upd_tag); end
    if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_commit_valid got %b want 0", commit_valid); end
    if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush got %b want 0", flush); end
    if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", full); end
    if (alloc_tag !== 4'd1) begin n_errors++; $display("FAIL reset_alloc_tag got %0d want 1", alloc_tag); end
    if (qready1 !== 1'b0) begin n_errors++; $display("FAIL reset_query_ready got %b want 0", qready1); end
    $display("test_reset done");
  endtask

  task automatic test_alloc_commit();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      decode_valid = 1; decode_rd = 5'(i); #1;
      n_checks++;
      if (alloc_tag !== 4'(i)) begin n_errors++; $display("FAIL alloc_tag got %0d want %0d", alloc_tag, i); end
      tick();
      n_checks++;
      if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL early_commit got %b want 0", commit_valid); end
    end
    idle();
    alu_valid = 1; alu_tag = 4'd2; alu_value = 32'h22; tick(); idle();
    n_checks += 3;
    if (upd_tag !== 4'd2) begin n_errors++; $display("FAIL update_tag got %0d want 2", upd_tag); end
    if (upd_value !== 32'h22) begin n_errors++; $display("FAIL update_value got %h want 22", upd_value); end
    tick();
    if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL commit_blocked got %b want 0", commit_valid); end
    alu_valid = 1; alu_tag = 4'd1; alu_value = 32'h11; tick(); idle();
    tick();
    n_checks += 2;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd1) begin n_errors++; $display("FAIL commit1 got v=%b tag=%0d want v=1 tag=1", commit_valid, commit_tag); end
    if (commit_rd !== 5'd1 || commit_value !== 32'h11) begin n_errors++; $display("FAIL commit1_data got rd=%0d val=%h want rd=1 val=11", commit_rd, commit_value); end
    tick();
    n_checks += 2;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd2) begin n_errors++; $display("FAIL commit2 got v=%b tag=%0d want v=1 tag=2", commit_valid, commit_tag); end
    if (commit_rd !== 5'd2 || commit_value !== 32'h22) begin n_errors++; $display("FAIL commit2_data got rd=%0d val=%h want rd=2 val=22", commit_rd, commit_value); end
    tick();
    n_checks++;
    if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL commit3_not_ready got %b want 0", commit_valid); end
    $display("test_alloc_commit done");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 15; i++) alloc(5'(i + 1));
    decode_valid = 1; decode_rd = 5'd9; #1;
    n_checks += 2;
    if (full !== 1'b1) begin n_errors++; $display("FAIL full_flag got %b want 1", full); end
    if (alloc_tag !== 4'd0) begin n_errors++; $display("FAIL full_alloc_tag got %0d want 0", alloc_tag); end
    alu_valid = 1; alu_tag = 4'd1; alu_value = 32'h1;
    tick();
    alu_valid = 0; #1;
    n_checks += 2;
    if (full !== 1'b1) begin n_errors++; $display("FAIL refused_full got %b want 1", full); end
    if (alloc_tag !== 4'd0) begin n_errors++; $display("FAIL commit_cycle_alloc got %0d want 0", alloc_tag); end
    tick();
    n_checks += 3;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd1) begin n_errors++; $display("FAIL full_commit got v=%b tag=%0d want v=1 tag=1", commit_valid, commit_tag); end
    if (full !== 1'b0) begin n_errors++; $display("FAIL after_commit_full got %b want 0", full); end
    if (alloc_tag !== 4'd1) begin n_errors++; $display("FAIL wrap_alloc_tag got %0d want 1", alloc_tag); end
    tick(); idle(); #1;
    n_checks++;
    if (full !== 1'b1) begin n_errors++; $display("FAIL refill_full got %b want 1", full); end
    $display("test_full done");
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1));
    qtag1 = 4'd5; qtag2 = 4'd4;
    alu_valid = 1; alu_tag = 4'd5; alu_value = 32'hABCD; #1;
    n_checks += 3;
    if (qready1 !== 1'b1) begin n_errors++; $display("FAIL bypass_ready got %b want 1", qready1); end
    if (qvalue1 !== 32'hABCD) begin n_errors++; $display("FAIL bypass_value got %h want abcd", qvalue1); end
    if (qready2 !== 1'b0) begin n_errors++; $display("FAIL other_ready got %b want 0", qready2); end
    qtag2 = 4'd0; #1;
    n_checks++;
    if (qready2 !== 1'b0) begin n_errors++; $display("FAIL tag0_ready got %b want 0", qready2); end
    tick();
    alu_valid = 0; #1;
    n_checks += 2;
    if (qready1 !== 1'b1) begin n_errors++; $display("FAIL stored_ready got %b want 1", qready1); end
    if (qvalue1 !== 32'hABCD) begin n_errors++; $display("FAIL stored_value got %h want abcd", qvalue1); end
    idle();
    $display("test_bypass done");
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1));
    alu_valid = 1; alu_tag = 4'd1; alu_value = 32'h55; alu_misp = 1; alu_target = 32'h100;
    tick();
    decode_valid = 1; decode_rd = 5'd7;
    alu_valid = 1; alu_tag = 4'd3; alu_value = 32'h33; alu_misp = 0;
    tick(); idle();
    n_checks += 5;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd1) begin n_errors++; $display("FAIL flush_commit got v=%b tag=%0d want v=1 tag=1", commit_valid, commit_tag); end
    if (commit_value !== 32'h55) begin n_errors++; $display("FAIL flush_link got %h want 55", commit_value); end
    if (flush !== 1'b1) begin n_errors++; $display("FAIL flush_pulse got %b want 1", flush); end
    if (flush_pc !== 32'h100) begin n_errors++; $display("FAIL flush_pc got %h want 100", flush_pc); end
    if (upd_tag !== 4'd0) begin n_errors++; $display("FAIL flush_update got %0d want 0", upd_tag); end
    qtag1 = 4'd3; #1;
    n_checks += 2;
    if (alloc_tag !== 4'd1) begin n_errors++; $display("FAIL post_flush_alloc got %0d want 1", alloc_tag); end
    if (qready1 !== 1'b0) begin n_errors++; $display("FAIL post_flush_query got %b want 0", qready1); end
    decode_valid = 1; decode_rd = 5'd4;
    tick(); idle();
    n_checks += 3;
    if (flush !== 1'b0) begin n_errors++; $display("FAIL flush_one_cycle got %b want 0", flush); end
    if (alloc_tag !== 4'd2) begin n_errors++; $display("FAIL count_one_tag got %0d want 2", alloc_tag); end
    if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL post_flush_commit got %b want 0", commit_valid); end
    $display("test_flush done");
  endtask

  task automatic test_rdy_stall();
    do_reset();
    alloc(5'd1); alloc(5'd2);
    rdy = 0; decode_valid = 1; decode_rd = 5'd3;
    alu_valid = 1; alu_tag = 4'd1; alu_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks += 3;
      if (upd_tag !== 4'd0) begin n_errors++; $display("FAIL stall_update got %0d want 0", upd_tag); end
      if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL stall_commit got %b want 0", commit_valid); end
      if (alloc_tag !== 4'd3) begin n_errors++; $display("FAIL stall_alloc_tag got %0d want 3", alloc_tag); end
    end
    rdy = 1; decode_valid = 0;
    tick(); idle();
    n_checks += 2;
    if (upd_tag !== 4'd1) begin n_errors++; $display("FAIL resume_update got %0d want 1", upd_tag); end
    if (upd_value !== 32'h77) begin n_errors++; $display("FAIL resume_value got %h want 77", upd_value); end
    tick();
    rdy = 0;
    tick(); tick();
    n_checks++;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd1 || commit_value !== 32'h77) begin
      n_errors++; $display("FAIL stall_hold_commit got v=%b tag=%0d val=%h want v=1 tag=1 val=77", commit_valid, commit_tag, commit_value);
    end
    rdy = 1;
    tick();
    n_checks++;
    if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL after_stall_commit got %b want 0", commit_valid); end
    $display("test_rdy_stall done");
  endtask

  task automatic test_random();
    int t1, t2;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rdy = ($urandom_range(0, 9) != 0);
      decode_valid = ($urandom_range(0, 9) < 6);
      decode_rd = 5'($urandom_range(0, 31));
      decode_pc = $urandom;
      alu_valid = $urandom_range(0, 1) == 1;
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) alu_tag = 4'(mq[$urandom_range(0, mq.size() - 1)]);
      else alu_tag = 4'($urandom_range(0, 15));
      alu_value = $urandom;
      alu_misp = ($urandom_range(0, 19) == 0);
      alu_target = $urandom;
      t1 = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)] : int'($urandom_range(0, 15));
      t2 = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)] : int'($urandom_range(0, 15));
      qtag1 = 4'(t1); qtag2 = 4'(t2);
      #1;
      n_checks += 4;
      if (full !== (mq.size() == 15)) begin n_errors++; $display("FAIL rnd_full cyc=%0d got %b want %b", cyc, full, mq.size() == 15); end
      if (alloc_tag !== ((mq.size() == 15) ? 4'd0 : 4'(m_next))) begin n_errors++; $display("FAIL rnd_alloc_tag cyc=%0d got %0d want %0d", cyc, alloc_tag, (mq.size() == 15) ? 0 : m_next); end
      if (qready1 !== m_qready(t1) || (m_qready(t1) && qvalue1 !== m_qvalue(t1))) begin
        n_errors++; $display("FAIL rnd_query1 cyc=%0d tag=%0d got r=%b v=%h want r=%b v=%h", cyc, t1, qready1, qvalue1, m_qready(t1), m_qvalue(t1));
      end
      if (qready2 !== m_qready(t2) || (m_qready(t2) && qvalue2 !== m_qvalue(t2))) begin
        n_errors++; $display("FAIL rnd_query2 cyc=%0d tag=%0d got r=%b v=%h want r=%b v=%h", cyc, t2, qready2, qvalue2, m_qready(t2), m_qvalue(t2));
      end
      tick();
      n_checks += 3;
      if (upd_tag !== e_upd_tag || (e_upd_tag != 0 && upd_value !== e_upd_val)) begin
        n_errors++; $display("FAIL rnd_update cyc=%0d got tag=%0d val=%h want tag=%0d val=%h", cyc, upd_tag, upd_value, e_upd_tag, e_upd_val);
      end
      if (commit_valid !== e_cv || (e_cv && (commit_tag !== e_ctag || commit_rd !== e_crd || commit_value !== e_cval))) begin
        n_errors++; $display("FAIL rnd_commit cyc=%0d got v=%b tag=%0d rd=%0d val=%h want v=%b tag=%0d rd=%0d val=%h",
                             cyc, commit_valid, commit_tag, commit_rd, commit_value, e_cv, e_ctag, e_crd, e_cval);
      end
      if (flush !== e_flush || (e_flush && flush_pc !== e_fpc)) begin
        n_errors++; $display("FAIL rnd_flush cyc=%0d got f=%b pc=%h want f=%b pc=%h", cyc, flush, flush_pc, e_flush, e_fpc);
      end
    end
    idle(); rdy = 1;
    $display("test_random done");
  endtask

  initial begin
    rst = 1; rdy = 1;
    idle();
    test_reset();
    test_alloc_commit();
    test_full();
    test_bypass();
    test_flush();
    test_rdy_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
